// File: rtl/param_counter_pkg.sv
// Shared types and constants for the param_counter slice.
// Down-count support is selected by PARAM_COUNTER_DOWN_EN in the files that use it.
package param_counter_pkg;

  localparam int DEFAULT_WIDTH = 6;

  // One bit is enough for the two-state run/halt machine.
  localparam int   STATE_W    = 1;
  localparam logic STATE_RUN  = 1'b0;
  localparam logic STATE_HALT = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    RUN  = STATE_RUN,
    HALT = STATE_HALT
  } state_t;

endpackage

// File: rtl/param_counter_if.sv
// Control/status bundle between a counter user (master) and param_counter (slave).
// The `up` direction signal exists only when PARAM_COUNTER_DOWN_EN is defined.
interface param_counter_if
  import param_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             oneshot;
`ifdef PARAM_COUNTER_DOWN_EN
  logic             up;
`endif
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             done;
  logic             halted;

  modport master (
`ifdef PARAM_COUNTER_DOWN_EN
    output up,
`endif
    output en, load, load_val, limit, oneshot,
    input  out, tc, wrap, done, halted
  );

  modport slave (
`ifdef PARAM_COUNTER_DOWN_EN
    input  up,
`endif
    input  en, load, load_val, limit, oneshot,
    output out, tc, wrap, done, halted
  );

endinterface

// File: rtl/param_counter_count_step.sv
// Combinational step logic: candidate next values in both directions and
// the terminal compare (limit when counting up, zero when counting down).
module count_step
  import param_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  output logic [WIDTH-1:0] next_up,
  output logic [WIDTH-1:0] next_down,
  output logic             at_terminal
);

  assign next_up     = out + WIDTH'(1);
  assign next_down   = out - WIDTH'(1);
  assign at_terminal = up ? (out == limit) : (out == '0);

endmodule

// File: rtl/param_counter.sv
// Parametrised cycle counter with load, programmable terminal, wrap/one-shot
// modes, wrap pulse and sticky done. Down counting needs PARAM_COUNTER_DOWN_EN.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               clr,
  param_counter_if.slave     bus
);

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic             wrap_q;
  logic             done_q;

  logic             up_w;
  logic [WIDTH-1:0] next_up_w;
  logic [WIDTH-1:0] next_down_w;
  logic             at_terminal_w;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_d;

`ifdef PARAM_COUNTER_DOWN_EN
  assign up_w = bus.up;
`else
  assign up_w = 1'b1;
`endif

  count_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .out         (out_q),
    .limit       (bus.limit),
    .up          (up_w),
    .next_up     (next_up_w),
    .next_down   (next_down_w),
    .at_terminal (at_terminal_w)
  );

  // Non-terminal step, and the value taken when a free-running wrap occurs.
  assign count_d  = up_w ? next_up_w : next_down_w;
  assign reload_d = up_w ? '0 : bus.limit;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RUN;
      out_q   <= RESET_VAL;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.load) begin
      state_q <= RUN;
      out_q   <= bus.load_val;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.en) begin
      wrap_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (at_terminal_w) begin
            if (bus.oneshot) begin
              state_q <= HALT;
              done_q  <= 1'b1;
            end else begin
              out_q  <= reload_d;
              wrap_q <= 1'b1;
            end
          end else begin
            out_q <= count_d;
          end
        end
        HALT: begin
          // Only load or clr leave HALT; enabled edges are ignored here.
        end
        default: state_q <= RUN;
      endcase
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.out    = out_q;
  assign bus.tc     = at_terminal_w;
  assign bus.wrap   = wrap_q;
  assign bus.done   = done_q;
  assign bus.halted = (state_q == HALT);

endmodule

// File: doc/param_counter.md
# param_counter

Parametrised WIDTH-bit synchronous counter that succeeds the fixed-width 3/4/6-bit counters used for multdiv cycle counting and timers. It adds a parallel load, a programmable terminal value, wrap/one-shot modes, a registered wrap pulse and a sticky done flag. An optional down-count mode is available. It sits beside the multdiv control FSM and the timer peripheral as their common cycle-count source.

## Interface
- WIDTH, 6: counter width in bits, 2..32.
- RESET_VAL, 0: value of out after reset, must be less than 2^WIDTH.

- clk  in  1: rising-edge clock.
- clr  in  1: asynchronous, active-low reset; clr=0 resets immediately.
- en  in  1: count enable, sampled at posedge.
- load  in  1: synchronous parallel load, higher priority than en.
- load_val  in  WIDTH: value taken by out on load.
- limit  in  WIDTH: terminal value (up) / reload value (down); sampled every cycle.
- oneshot  in  1: 1 = stop at terminal, 0 = free-running wrap.
- up  in  1: direction, 1 = up; port exists only with PARAM_COUNTER_DOWN_EN.
- out  out  WIDTH: registered count.
- tc  out  1: combinational, out equals current terminal value.
- wrap  out  1: registered one-cycle pulse on each free-running wrap.
- done  out  1: registered, sticky; set when a one-shot run completes.
- halted  out  1: registered, state == HALT.

## Operation
- Two states: RUN and HALT.
- Terminal value: `limit` when counting up, 0 when counting down.
- Priority at each posedge: clr (async) > load > en > hold.
- Reset (clr=0), applied asynchronously:
  - out=RESET_VAL, state=RUN, done=0, wrap=0.
- load=1, any state:
  - out=load_val, state=RUN, done=0, wrap=0.
- RUN, en=1, up, out≠limit: out=out+1, modulo 2^WIDTH.
  - An out above limit therefore rolls 2^WIDTH-1 → 0 without a wrap pulse.
- RUN, en=1, up, out==limit:
  - oneshot=0: out=0, wrap=1.
  - oneshot=1: out holds, state=HALT, done=1.
- RUN, en=1, down, out≠0: out=out-1.
- RUN, en=1, down, out==0:
  - oneshot=0: out=limit, wrap=1.
  - oneshot=1: out holds, state=HALT, done=1.
- HALT: en is ignored and out holds. Only load or clr leave HALT.
- en=0 in either state: all registers hold, except wrap, which clears.
- wrap is high for exactly one cycle per wrap event.
- limit=0 in up mode:
  - free-running: out stays 0 and wrap=1 every enabled cycle.
  - one-shot: halts on the first enabled cycle.
- A change of limit or oneshot mid-run takes effect at the next compare. Neither restarts the count.

## Timing
- out, wrap, done and halted change only on posedge clk or on clr falling.
- Load-to-out latency is 1 cycle.
- Count latency is 1 cycle per enabled edge.
- tc is combinational from out, up and limit, with no added latency.
  - tc is high in the same cycle that the terminal edge is about to occur.
- done and halted rise on the edge that processes the terminal count, 1 cycle after tc is first seen with en=1.
- A clr pulse mid-run aborts the run. The counter restarts from RESET_VAL in RUN.

## Configuration
- PARAM_COUNTER_DOWN_EN defined:
  - the `up` port exists and down-count behaviour is compiled in;
  - tc compares against 0 when up=0.
- Undefined:
  - no `up` port, up-count only;
  - terminal value is always limit.

## Structure
- Package `param_counter_pkg` holds:
  - the state typedef (RUN, HALT);
  - the default WIDTH constant;
  - a localparam for the state encoding.
- One sub-module, `count_step`: combinational next-value and terminal-compare logic.
  - Inputs: out, limit, up.
  - Outputs: next_up/next_down value, at_terminal.
- The top level holds the registers, the FSM and the load/enable priority.

## Test plan
- Reset and count: WIDTH=4; clr low then high; en=1, oneshot=0, limit=15; 20 cycles.
  - out 0→15→0→3; wrap high exactly on the 15→0 edge.
- Limit wrap: limit=5, en=1, oneshot=0.
  - out sequence 0,1,2,3,4,5,0; tc high while out=5; one wrap pulse.
- One-shot: load_val=2, load=1 for 1 cycle, limit=4, oneshot=1.
  - out 2,3,4 then holds 4; done=1 and halted=1 from the edge after out=4.
  - en toggling has no effect; a new load clears done.
- Load priority: load=1 and en=1 with load_val=9 while out=3.
  - out=9 next cycle, not 4.
- Async reset mid-run: pull clr low between edges while out=7.
  - out=RESET_VAL immediately, without waiting for a clock edge; done=0 and wrap=0.
- Down mode (PARAM_COUNTER_DOWN_EN): up=0, limit=3, load_val=1, oneshot=0.
  - out 1,0,3,2,1,0,3; wrap on each 0→3 edge.
